board_renderer: RTL and testbench



---
 rtl/othello_pkg.sv | 35 +++
 rtl/board_renderer_cell_shader.sv | 45 ++++
 rtl/board_renderer.sv | 205 ++++++++++++++++++++
 tb/tb_board_renderer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared types and constants for the Othello board display path.
package othello_pkg;

    // Contents of one board RAM entry
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BLACK = 2'd1,
        CELL_WHITE = 2'd2,
        CELL_HINT  = 2'd3
    } cell_state_t;

    // 3-bit RGB colours understood by the VGA adapter
    localparam logic [2:0] COL_GRID   = 3'b000;
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_CURSOR = 3'b110;
    localparam logic [2:0] COL_HINT   = 3'b101;
    localparam logic [2:0] COL_BOARD  = 3'b010;

    // Renderer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } render_state_t;

    // True when lo <= v <= hi; an empty window (hi < lo) never matches
    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/board_renderer_cell_shader.sv
// Pure combinational pixel colour for one position inside a board cell.
module cell_shader
    import othello_pkg::*;
#(
    parameter int CELL_PX    = 14,
    parameter int DISK_INSET = 2,
    parameter int PW         = $clog2(CELL_PX)
) (
    input  logic [PW-1:0] px,
    input  logic [PW-1:0] py,
    input  cell_state_t   state,
    input  logic          is_cursor,
    output logic [2:0]    colour
);

    // Windows are signed so that a hint square larger than the cell collapses to empty
    localparam int D_LO = DISK_INSET;
    localparam int D_HI = CELL_PX - 1 - DISK_INSET;
    localparam int H_LO = 2 * DISK_INSET;
    localparam int H_HI = CELL_PX - 1 - 2 * DISK_INSET;

    logic disk_s;
    logic hint_s;

    // Membership of the current pixel in the disk and hint squares
    always_comb begin
        disk_s = in_window(int'(px), D_LO, D_HI) && in_window(int'(py), D_LO, D_HI);
        hint_s = in_window(int'(px), H_LO, H_HI) && in_window(int'(py), H_LO, H_HI);
    end

    // Priority colour selection: border, then disk, then hint, then felt
    always_comb begin
        colour = COL_BOARD;
        if ((px == '0) || (py == '0)) begin
            colour = is_cursor ? COL_CURSOR : COL_GRID;
        end else if (((state == CELL_BLACK) || (state == CELL_WHITE)) && disk_s) begin
            colour = (state == CELL_BLACK) ? COL_BLACK : COL_WHITE;
        end else if ((state == CELL_HINT) && hint_s) begin
            colour = COL_HINT;
        end else begin
            colour = COL_BOARD;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Othello board painter: walks cells, fetches their state and plots one pixel per cycle.
module board_renderer
    import othello_pkg::*;
#(
    parameter int BOARD_N    = 8,
    parameter int CELL_PX    = 14,
    parameter int DISK_INSET = 2,
    parameter int X0         = 16,
    parameter int Y0         = 4,
    parameter int XW         = 8,
    parameter int YW         = 7,
    localparam int IW        = $clog2(BOARD_N),
    localparam int AW        = $clog2(BOARD_N * BOARD_N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [IW-1:0] cell_x,
    input  logic [IW-1:0] cell_y,
    input  logic [IW-1:0] cursor_x,
    input  logic [IW-1:0] cursor_y,
    input  logic          cursor_en,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [2:0]    colour,
    output logic          plot,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int PW = $clog2(CELL_PX);
    localparam logic [PW-1:0] PX_LAST   = PW'(CELL_PX - 1);
    localparam logic [IW-1:0] CELL_LAST = IW'(BOARD_N - 1);
    localparam logic [XW-1:0] X0_W      = XW'(X0);
    localparam logic [YW-1:0] Y0_W      = YW'(Y0);
    localparam logic [XW-1:0] PITCH_X   = XW'(CELL_PX);
    localparam logic [YW-1:0] PITCH_Y   = YW'(CELL_PX);
    localparam logic [AW-1:0] ROW_W     = AW'(BOARD_N);

    // Geometry must fit the coordinate buses so pixel arithmetic never wraps
    if ((X0 + BOARD_N * CELL_PX - 1) >= (1 << XW)) begin : g_x_range
        $error("board_renderer: board does not fit in XW bits");
    end
    if ((Y0 + BOARD_N * CELL_PX - 1) >= (1 << YW)) begin : g_y_range
        $error("board_renderer: board does not fit in YW bits");
    end

    render_state_t state_r;
    render_state_t state_n;
    logic          mode_r;
    logic [IW-1:0] cx_r;
    logic [IW-1:0] cy_r;
    logic [IW-1:0] cur_x_r;
    logic [IW-1:0] cur_y_r;
    logic          cur_en_r;
    logic [PW-1:0] px_r;
    logic [PW-1:0] py_r;
    cell_state_t   cell_r;
    logic          err_r;
    logic          reject_s;
    logic          last_cell_s;
    logic          last_px_s;
    logic          is_cursor_s;
    logic [2:0]    shade_s;

    // Single-cell requests outside the board are refused without drawing
    assign reject_s    = mode && ((int'(cell_x) >= BOARD_N) || (int'(cell_y) >= BOARD_N));
    assign last_cell_s = (cx_r == CELL_LAST) && (cy_r == CELL_LAST);
    assign last_px_s   = (px_r == PX_LAST) && (py_r == PX_LAST);
    assign is_cursor_s = cur_en_r && (cx_r == cur_x_r) && (cy_r == cur_y_r);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = reject_s ? ST_DONE : ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: state_n = ST_WAIT;
            ST_WAIT:  state_n = ST_DRAW;
            ST_DRAW: begin
                if (last_px_s) begin
                    state_n = ST_NEXT;
                end else begin
                    state_n = ST_DRAW;
                end
            end
            ST_NEXT: begin
                if (mode_r || last_cell_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Request capture, cell pointer walk, pixel sweep and cell-state latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_r   <= 1'b0;
            cx_r     <= '0;
            cy_r     <= '0;
            cur_x_r  <= '0;
            cur_y_r  <= '0;
            cur_en_r <= 1'b0;
            px_r     <= '0;
            py_r     <= '0;
            cell_r   <= CELL_EMPTY;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        cur_x_r  <= cursor_x;
                        cur_y_r  <= cursor_y;
                        cur_en_r <= cursor_en;
                        err_r    <= reject_s;
                        cx_r     <= mode ? cell_x : '0;
                        cy_r     <= mode ? cell_y : '0;
                        px_r     <= '0;
                        py_r     <= '0;
                    end
                end
                ST_WAIT: begin
                    cell_r <= cell_state_t'(rd_data);
                    px_r   <= '0;
                    py_r   <= '0;
                end
                ST_DRAW: begin
                    if (px_r == PX_LAST) begin
                        px_r <= '0;
                        py_r <= py_r + PW'(1);
                    end else begin
                        px_r <= px_r + PW'(1);
                    end
                end
                ST_NEXT: begin
                    if (!mode_r && !last_cell_s) begin
                        if (cx_r == CELL_LAST) begin
                            cx_r <= '0;
                            cy_r <= cy_r + IW'(1);
                        end else begin
                            cx_r <= cx_r + IW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    cell_shader #(
        .CELL_PX    (CELL_PX),
        .DISK_INSET (DISK_INSET),
        .PW         (PW)
    ) u_shader (
        .px        (px_r),
        .py        (py_r),
        .state     (cell_r),
        .is_cursor (is_cursor_s),
        .colour    (shade_s)
    );

    // Outputs decoded purely from registered state; pixel bus is zero outside DRAW
    always_comb begin
        plot    = (state_r == ST_DRAW);
        busy    = (state_r == ST_FETCH) || (state_r == ST_WAIT) ||
                  (state_r == ST_DRAW)  || (state_r == ST_NEXT);
        done    = (state_r == ST_DONE);
        err     = err_r;
        rd_addr = AW'(cy_r) * ROW_W + AW'(cx_r);
        if (plot) begin
            x_out  = X0_W + XW'(cx_r) * PITCH_X + XW'(px_r);
            y_out  = Y0_W + YW'(cy_r) * PITCH_Y + YW'(py_r);
            colour = shade_s;
        end else begin
            x_out  = '0;
            y_out  = '0;
            colour = 3'b000;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench: default 8x8 renderer plus a 5x5/8px instance for range and hint cases.
module tb_board_renderer;

    localparam int NA = 8, CA = 14, IA = 2;
    localparam int NB = 5, CB = 8,  IB = 2;
    localparam int XO = 16, YO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       start_a = 1'b0, mode_a = 1'b0, cursor_en_a = 1'b0;
    logic [2:0] cell_x_a = 3'd0, cell_y_a = 3'd0, cursor_x_a = 3'd0, cursor_y_a = 3'd0;
    logic [5:0] rd_addr_a;
    logic [1:0] rd_data_a = 2'd0;
    logic [7:0] x_out_a;
    logic [6:0] y_out_a;
    logic [2:0] colour_a;
    logic       plot_a, busy_a, done_a, err_a;

    logic       start_b = 1'b0, mode_b = 1'b0, cursor_en_b = 1'b0;
    logic [2:0] cell_x_b = 3'd0, cell_y_b = 3'd0, cursor_x_b = 3'd0, cursor_y_b = 3'd0;
    logic [4:0] rd_addr_b;
    logic [1:0] rd_data_b = 2'd0;
    logic [7:0] x_out_b;
    logic [6:0] y_out_b;
    logic [2:0] colour_b;
    logic       plot_b, busy_b, done_b, err_b;

    int mem_a [NA*NA];
    int mem_b [NB*NB];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int n_checks = 0;
    int n_errors = 0;
    int plot_cnt_a = 0, plot_cnt_b = 0;
    bit first_ok_a = 1'b0;
    logic [31:0] first_pix_a = 32'd0, last_pix_a = 32'd0;

    board_renderer dut_a (
        .clock(clock), .reset(reset), .start(start_a), .mode(mode_a),
        .cell_x(cell_x_a), .cell_y(cell_y_a), .cursor_x(cursor_x_a), .cursor_y(cursor_y_a),
        .cursor_en(cursor_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .x_out(x_out_a), .y_out(y_out_a), .colour(colour_a), .plot(plot_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    board_renderer #(.BOARD_N(NB), .CELL_PX(CB), .DISK_INSET(IB)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .mode(mode_b),
        .cell_x(cell_x_b), .cell_y(cell_y_b), .cursor_x(cursor_x_b), .cursor_y(cursor_y_b),
        .cursor_en(cursor_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .x_out(x_out_b), .y_out(y_out_b), .colour(colour_b), .plot(plot_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clock = ~clock;

    // Board RAMs with one-cycle read latency
    always @(posedge clock) begin
        rd_data_a <= 2'(mem_a[rd_addr_a]);
        rd_data_b <= 2'(mem_b[rd_addr_b]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y, input int c);
        return 32'((x << 16) | (y << 4) | c);
    endfunction

    // Reference colour straight from the cell drawing rules
    function automatic int ref_colour(input int px, input int py, input int st,
                                      input bit cur, input int cpx, input int ins);
        if (px == 0 || py == 0) return cur ? 6 : 0;
        if ((st == 1 || st == 2) && px >= ins && px <= cpx-1-ins && py >= ins && py <= cpx-1-ins)
            return (st == 1) ? 0 : 7;
        if (st == 3 && px >= 2*ins && px <= cpx-1-2*ins && py >= 2*ins && py <= cpx-1-2*ins)
            return 5;
        return 2;
    endfunction

    // Expected pixel stream of one render, in drawing order
    task automatic build(input bit which, input bit md, input int cx, input int cy,
                         input int curx, input int cury, input bit cen);
        int n, cpx, ins, st;
        bit cur;
        n   = which ? NB : NA;
        cpx = which ? CB : CA;
        ins = which ? IB : IA;
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                if (!md || (x == cx && y == cy)) begin
                    st  = which ? mem_b[y*n+x] : mem_a[y*n+x];
                    cur = cen && (x == curx) && (y == cury);
                    for (int py = 0; py < cpx; py++) begin
                        for (int px = 0; px < cpx; px++) begin
                            if (which)
                                exp_b.push_back(pack(XO+x*cpx+px, YO+y*cpx+py,
                                                     ref_colour(px, py, st, cur, cpx, ins)));
                            else
                                exp_a.push_back(pack(XO+x*cpx+px, YO+y*cpx+py,
                                                     ref_colour(px, py, st, cur, cpx, ins)));
                        end
                    end
                end
            end
        end
    endtask

    // Every plotted pixel is compared against the head of the expected stream
    always @(negedge clock) begin
        if (plot_a) begin
            if (exp_a.size() == 0) check("extra_pixel_a", pack(x_out_a, y_out_a, colour_a), 32'hFFFF_FFFF);
            else check("pixel_a", pack(x_out_a, y_out_a, colour_a), exp_a.pop_front());
            if (!first_ok_a) begin
                first_pix_a = pack(x_out_a, y_out_a, colour_a);
                first_ok_a  = 1'b1;
            end
            last_pix_a = pack(x_out_a, y_out_a, colour_a);
            plot_cnt_a++;
        end
        if (plot_b) begin
            if (exp_b.size() == 0) check("extra_pixel_b", pack(x_out_b, y_out_b, colour_b), 32'hFFFF_FFFF);
            else check("pixel_b", pack(x_out_b, y_out_b, colour_b), exp_b.pop_front());
            plot_cnt_b++;
        end
    end

    task automatic drive(input bit which, input bit st, input bit md, input int cx, input int cy,
                         input int curx, input int cury, input bit cen);
        if (which) begin
            start_b = st; mode_b = md; cell_x_b = 3'(cx); cell_y_b = 3'(cy);
            cursor_x_b = 3'(curx); cursor_y_b = 3'(cury); cursor_en_b = cen;
        end else begin
            start_a = st; mode_a = md; cell_x_a = 3'(cx); cell_y_a = 3'(cy);
            cursor_x_a = 3'(curx); cursor_y_a = 3'(cury); cursor_en_a = cen;
        end
    endtask

    // One render from start to done with latency, address, pixel-count and err checks
    task automatic run(input bit which, input bit md, input int cx, input int cy,
                       input int curx, input int cury, input bit cen, input bit poke);
        int n, cpx, lat, cells, c;
        bit rej;
        n     = which ? NB : NA;
        cpx   = which ? CB : CA;
        rej   = md && (cx >= n || cy >= n);
        cells = md ? 1 : n*n;
        lat   = rej ? 1 : 1 + cells*(cpx*cpx+3);
        if (!rej) build(which, md, cx, cy, curx, cury, cen);
        plot_cnt_a = 0; plot_cnt_b = 0; first_ok_a = 1'b0;
        @(negedge clock);
        drive(which, 1'b1, md, cx, cy, curx, cury, cen);
        @(posedge clock); #1;
        // scramble the inputs: latched copies must be used from here on
        drive(which, 1'b0, $urandom_range(0,1), $urandom_range(0,7), $urandom_range(0,7),
              $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,1));
        c = 1;
        if (!rej) begin
            check("first_addr", which ? 32'(rd_addr_b) : 32'(rd_addr_a), md ? 32'(cy*n+cx) : 32'd0);
            check("busy_start", which ? 32'(busy_b) : 32'(busy_a), 32'd1);
        end
        while (!(which ? done_b : done_a) && c < lat + 100) begin
            if (poke && c == 20) drive(which, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
            if (poke && c == 21) drive(which, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
            @(posedge clock); #1;
            c++;
        end
        check("done_latency", 32'(c), 32'(lat));
        check("err_at_done", which ? 32'(err_b) : 32'(err_a), 32'(rej));
        check("busy_at_done", which ? 32'(busy_b) : 32'(busy_a), 32'd0);
        check("plot_count", which ? 32'(plot_cnt_b) : 32'(plot_cnt_a), rej ? 32'd0 : 32'(cells*cpx*cpx));
        check("pixels_left", which ? 32'(exp_b.size()) : 32'(exp_a.size()), 32'd0);
        @(posedge clock); #1;
        check("done_pulse", which ? 32'(done_b) : 32'(done_a), 32'd0);
        check("err_held", which ? 32'(err_b) : 32'(err_a), 32'(rej));
        exp_a.delete(); exp_b.delete();
    endtask

    initial begin
        for (int i = 0; i < NA*NA; i++) mem_a[i] = 0;
        for (int i = 0; i < NB*NB; i++) mem_b[i] = 3;

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_a", {x_out_a, y_out_a, colour_a, plot_a, busy_a, done_a, err_a, rd_addr_a},
              32'd0);
        check("reset_outputs_b", {plot_b, busy_b, done_b, err_b, x_out_b, y_out_b}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Empty board, full redraw
        run(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        check("first_pixel", first_pix_a, pack(16, 4, 0));
        check("last_pixel", last_pix_a, pack(127, 115, 2));

        // Single black cell at (3,4)
        mem_a[35] = 1;
        run(1'b0, 1'b1, 3, 4, 0, 0, 1'b0, 1'b0);

        // White corner cell under the cursor, highlighted then not
        mem_a[63] = 2;
        run(1'b0, 1'b1, 7, 7, 7, 7, 1'b1, 1'b0);
        run(1'b0, 1'b1, 7, 7, 7, 7, 1'b0, 1'b0);

        // start pulses during a render are ignored
        run(1'b0, 1'b1, 3, 4, 3, 4, 1'b1, 1'b1);

        // Reset in the middle of DRAW
        build(1'b0, 1'b1, 2, 2, 0, 0, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 2, 2, 0, 0, 1'b0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        repeat (60) begin
            @(posedge clock); #1;
        end
        check("mid_plot", 32'(plot_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_drops_plot", 32'(plot_a), 32'd0);
        check("reset_drops_busy", 32'(busy_a), 32'd0);
        check("reset_no_done", 32'(done_a), 32'd0);
        exp_a.delete();
        repeat (2) begin
            @(posedge clock); #1;
        end
        check("reset_still_idle", {plot_a, busy_a, done_a}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run(1'b0, 1'b1, 2, 2, 0, 0, 1'b0, 1'b0);

        // Random board, full redraw with random cursor
        for (int i = 0; i < NA*NA; i++) mem_a[i] = $urandom_range(0, 3);
        run(1'b0, 1'b0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7), 1'b1, 1'b0);

        // Random single-cell redraws
        for (int k = 0; k < 6; k++) begin
            run(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Small board: out-of-range requests, recovery, hint cells, full redraw
        run(1'b1, 1'b1, 5, 0, 0, 0, 1'b0, 1'b0);
        run(1'b1, 1'b1, 4, 4, 4, 4, 1'b1, 1'b0);
        run(1'b1, 1'b1, 1, 7, 0, 0, 1'b0, 1'b0);
        mem_b[6]  = 1;
        mem_b[12] = 2;
        run(1'b1, 1'b0, 7, 7, 2, 2, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run(1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
